// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_IDLE
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // aclk cycles per line bit (truncating); the transmitter uses the same rounding
    function automatic int cycles_per_bit(input int clk_freq_mhz, input int bit_rate);
        return (clk_freq_mhz * 1000000) / bit_rate;
    endfunction

endpackage

// File: rtl/uart_rx_to_axis_if.sv
// Single-beat AXI-Stream link carrying one received UART word.
interface uart_rx_to_axis_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line plus falling-edge detect.
// Flops reset to 1 (line idle) so reset release never looks like a start edge.
module uart_rx_sync (
    input  logic aclk,
    input  logic aresetn,
    input  logic rx,
    output logic rxs,
    output logic fall
);
    logic meta;
    logic rxs_prev;

    // metastability stage, synchronised line, and one cycle of history for edge detect
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            meta     <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            meta     <= rx;
            rxs      <= meta;
            rxs_prev <= rxs;
        end
    end

    assign fall = rxs_prev & ~rxs;
endmodule

// File: rtl/uart_rx_to_axis.sv
// UART receiver delivering each good word as one AXI-Stream beat.
// Framing/parity/overrun events are reported as single-cycle pulses.
module uart_rx_to_axis
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 100,
    parameter int BIT_RATE      = 115200,
    parameter int BIT_PER_WORD  = 8,
    parameter int PARITY_BIT    = 0,
    parameter int STOP_BITS_NUM = 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      RX,
    uart_rx_to_axis_if.master         m_axis,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      overrun
);
    localparam int              P      = cycles_per_bit(CLK_FREQ, BIT_RATE);
    localparam int              TW     = $clog2(P);
    localparam logic [TW-1:0]   T_HALF = TW'(P / 2);
    localparam logic [TW-1:0]   T_LAST = TW'(P - 1);
    localparam logic [2:0]      B_LAST = 3'(BIT_PER_WORD - 1);

    rx_state_t     state_q, state_d;
    logic          rxs, fall;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          par_bad_q;
    logic          sample;
    logic          par_exp;
    logic [7:0]    word;
    logic          fe_ev, pe_ev, good_ev;
    logic          hold_busy;

    uart_rx_sync u_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .rx      (RX),
        .rxs     (rxs),
        .fall    (fall)
    );

    // The start bit is sampled mid-bit; the timer is then zeroed there so every
    // later bit is sampled one full period on, i.e. also mid-bit.
    assign sample    = (state_q == START) ? (timer_q == T_HALF) : (timer_q == T_LAST);
    // Bits are shifted in from the top, so unused low bits stay 0 and the XOR
    // over the whole register equals the XOR over the data bits.
    assign par_exp   = (PARITY_BIT == PARITY_ODD) ? ~^shreg_q : ^shreg_q;
    assign word      = shreg_q >> (8 - BIT_PER_WORD);
    assign hold_busy = m_axis.tvalid && !m_axis.tready;

    // state register
    always_ff @(posedge aclk) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next state and per-frame completion events
    always_comb begin
        state_d = state_q;
        fe_ev   = 1'b0;
        pe_ev   = 1'b0;
        good_ev = 1'b0;
        case (state_q)
            IDLE:   if (fall) state_d = START;
            START:  if (sample) state_d = rxs ? IDLE : DATA;
            DATA:   if (sample && bit_cnt_q == B_LAST)
                        state_d = (PARITY_BIT != PARITY_NONE) ? PARITY : STOP1;
            PARITY: if (sample) state_d = STOP1;
            STOP1, STOP2: begin
                if (sample) begin
                    if (!rxs) begin
                        fe_ev   = 1'b1;
                        state_d = WAIT_IDLE;
                    end else if (state_q == STOP1 && STOP_BITS_NUM == 2) begin
                        state_d = STOP2;
                    end else begin
                        // leave at the stop-bit midpoint so the next start edge is seen early
                        pe_ev   = par_bad_q;
                        good_ev = !par_bad_q;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: if (rxs) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // bit timer, bit counter, shift register and parity flag
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            if (state_q == IDLE || state_q == WAIT_IDLE || sample) timer_q <= '0;
            else                                                   timer_q <= timer_q + 1'b1;
            if (sample) begin
                if (state_q == START) begin
                    bit_cnt_q <= '0;
                    shreg_q   <= '0;
                    par_bad_q <= 1'b0;
                end else if (state_q == DATA) begin
                    shreg_q   <= {rxs, shreg_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end else if (state_q == PARITY) begin
                    par_bad_q <= (rxs != par_exp);
                end
            end
        end
    end

    // stream output register and status pulses; a held word is never replaced
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            frame_err     <= 1'b0;
            parity_err    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_err  <= fe_ev;
            parity_err <= pe_ev;
            overrun    <= good_ev && hold_busy;
            if (good_ev && !hold_busy) begin
                m_axis.tdata  <= word;
                m_axis.tvalid <= 1'b1;
            end else if (m_axis.tvalid && m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_to_axis.sv
// Bench for uart_rx_to_axis: three instances (8N1, 8E1, 8N2) driven in parallel,
// expected beats queued by a frame-level model, checked by a separate monitor.
module tb_uart_rx_to_axis;
    localparam int P = (100 * 1000000) / 115200;

    logic       aclk = 1'b0;
    logic [2:0] rx   = '1;
    logic [2:0] rdy  = '1;
    logic [2:0] rstn = '0;
    logic [2:0][7:0] td;
    logic [2:0] tv, fe, pe, ov;

    always #5 aclk = ~aclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int PB = (g == 1) ? 2 : 0;
        localparam int SB = (g == 2) ? 2 : 1;
        uart_rx_to_axis_if axis ();
        assign axis.tready = rdy[g];
        assign td[g] = axis.tdata;
        assign tv[g] = axis.tvalid;
        uart_rx_to_axis #(
            .CLK_FREQ(100), .BIT_RATE(115200), .BIT_PER_WORD(8),
            .PARITY_BIT(PB), .STOP_BITS_NUM(SB)
        ) dut (
            .aclk       (aclk),
            .aresetn    (rstn[g]),
            .RX         (rx[g]),
            .m_axis     (axis),
            .frame_err  (fe[g]),
            .parity_err (pe[g]),
            .overrun    (ov[g])
        );
    end

    logic [7:0] exp_q [3][$];
    int exp_fe [3], exp_pe [3], exp_ov [3];
    int got_fe [3], got_pe [3], got_ov [3];
    bit held [3];
    int n_vec = 0, n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Pops an expected word on every handshake; counts status pulses.
    task automatic monitor();
        forever begin
            @(negedge aclk);
            for (int g = 0; g < 3; g++) begin
                if (fe[g] === 1'b1) got_fe[g]++;
                if (pe[g] === 1'b1) got_pe[g]++;
                if (ov[g] === 1'b1) got_ov[g]++;
                if (tv[g] === 1'b1 && rdy[g]) begin
                    if (exp_q[g].size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL beat_inst%0d: got unexpected tdata %0h, expected no beat", g, td[g]);
                    end else begin
                        automatic logic [7:0] e = exp_q[g].pop_front();
                        check($sformatf("beat_inst%0d", g), int'(td[g]), int'(e));
                    end
                end
            end
        end
    endtask

    // Frame-level model decides the outcome, then the frame is shifted out on rx[g].
    task automatic send(input int g, input logic [7:0] d, input bit bad_par,
                        input bit bad_stop, input bit record);
        int  pmode = (g == 1) ? 2 : 0;
        int  nstop = (g == 2) ? 2 : 1;
        logic pbit;
        pbit = (pmode == 1) ? ~(^d) : ^d;
        if (bad_par) pbit = ~pbit;
        if (record) begin
            if (bad_stop)                                exp_fe[g]++;
            else if (pmode != 0 && bad_par)              exp_pe[g]++;
            else if (!rdy[g] && held[g])                 exp_ov[g]++;
            else begin
                exp_q[g].push_back(d);
                if (!rdy[g]) held[g] = 1'b1;
            end
        end
        rx[g] = 1'b0;
        wait_cyc(P);
        for (int i = 0; i < 8; i++) begin
            rx[g] = d[i];
            wait_cyc(P);
        end
        if (pmode != 0) begin
            rx[g] = pbit;
            wait_cyc(P);
        end
        for (int s = 0; s < nstop; s++) begin
            rx[g] = !(s == 0 && bad_stop);
            wait_cyc(P);
        end
    endtask

    task automatic check_reset_vals(input int g, input string tag);
        check({tag, "_tvalid"}, int'(tv[g]), 0);
        check({tag, "_tdata"}, int'(td[g]), 0);
        check({tag, "_pulses"}, int'({fe[g], pe[g], ov[g]}), 0);
    endtask

    // 8N1: basic beat, overrun under backpressure, glitch, random, reset mid-frame
    task automatic run0();
        send(0, 8'hA5, 0, 0, 1);
        wait_cyc(P);
        rdy[0] = 1'b0;
        send(0, 8'h11, 0, 0, 1);
        send(0, 8'h22, 0, 0, 1);
        wait_cyc(20);
        check("overrun_count_mid", got_ov[0], exp_ov[0]);
        check("held_tdata", int'(td[0]), 'h11);
        check("held_tvalid", int'(tv[0]), 1);
        rdy[0] = 1'b1;
        held[0] = 1'b0;
        wait_cyc(10);
        rx[0] = 1'b0;
        wait_cyc(300);
        rx[0] = 1'b1;
        wait_cyc(P);
        check("glitch_pulses", got_fe[0] + got_pe[0], 0);
        for (int k = 0; k < 2; k++) begin
            send(0, 8'($urandom), 0, 0, 1);
            wait_cyc($urandom_range(0, P));
        end
        fork
            send(0, 8'h5A, 0, 0, 0);
            begin
                wait_cyc(4 * P);
                rstn[0] = 1'b0;
                wait_cyc(3);
                check_reset_vals(0, "midreset");
            end
        join
        wait_cyc(5);
        rstn[0] = 1'b1;
        wait_cyc(P);
        send(0, 8'h3C, 0, 0, 1);
        wait_cyc(P);
    endtask

    // 8E1: good and bad parity, then stop-bit low with a long break
    task automatic run1();
        send(1, 8'h37, 0, 0, 1);
        send(1, 8'h37, 1, 0, 1);
        wait_cyc(P);
        check("parity_err_count_mid", got_pe[1], exp_pe[1]);
        send(1, 8'h55, 0, 1, 1);
        wait_cyc(20 * P);
        check("frame_err_count_mid", got_fe[1], exp_fe[1]);
        check("break_no_tvalid", int'(tv[1]), 0);
        rx[1] = 1'b1;
        wait_cyc(P);
        send(1, 8'h12, 0, 0, 1);
        wait_cyc(P);
    endtask

    // 8N2: back-to-back frames with no idle gap, then random words and gaps
    task automatic run2();
        send(2, 8'h00, 0, 0, 1);
        send(2, 8'hFF, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            send(2, 8'($urandom), 0, 0, 1);
            wait_cyc($urandom_range(0, P / 2));
        end
        wait_cyc(P);
    endtask

    initial begin
        fork
            monitor();
        join_none
        wait_cyc(5);
        for (int g = 0; g < 3; g++) check_reset_vals(g, $sformatf("reset_inst%0d", g));
        rstn = '1;
        wait_cyc(5);
        fork
            run0();
            run1();
            run2();
        join
        wait_cyc(10);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("leftover_beats_inst%0d", g), exp_q[g].size(), 0);
            check($sformatf("frame_err_inst%0d", g), got_fe[g], exp_fe[g]);
            check($sformatf("parity_err_inst%0d", g), got_pe[g], exp_pe[g]);
            check($sformatf("overrun_inst%0d", g), got_ov[g], exp_ov[g]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
